fft_seq_ctrl: RTL and testbench

FFT_SEQ_CTRL -- requirements
Module: fft_seq_ctrl

---
 rtl/fft_seq_ctrl.sv | 204 ++++++++++++++++++++
 tb/tb_fft_seq_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fft_seq_ctrl.sv
// Sequencer for an in-place radix-2 DIT FFT: bit-reversed sample load, butterfly
// address/twiddle generation with a fixed latency pipeline per butterfly, and host RAM access.
module fft_seq_ctrl #(
  parameter int N_POINTS = 16,
  parameter int RD_LAT   = 2,
  parameter int MUL_LAT  = 1,
  parameter int ADD_LAT  = 1,
  localparam int L  = $clog2(N_POINTS),
  localparam int AW = L,
  localparam int SW = $clog2(L) + 1
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic          abort_i,
  input  logic          read_ram_i,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  output logic          wr_mem_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          rd_mem_o,
  output logic [AW-1:0] rd_addr_a_o,
  output logic [AW-1:0] rd_addr_b_o,
  output logic [AW-2:0] tw_idx_o,
  output logic [SW-1:0] stage_o,
  output logic          host_sel_o,
  output logic          busy_o,
  output logic          done_o,
  output logic [3:0]    state_o
);

  localparam int TW      = AW - 1;
  localparam int BW      = AW - 1;
  localparam int MAX_LAT = (RD_LAT > MUL_LAT) ? ((RD_LAT > ADD_LAT) ? RD_LAT : ADD_LAT)
                                              : ((MUL_LAT > ADD_LAT) ? MUL_LAT : ADD_LAT);
  localparam int CW      = $clog2(MAX_LAT + 1);

  typedef enum logic [3:0] {
    IDLE    = 4'd0,
    LOAD    = 4'd1,
    RD      = 4'd2,
    MUL     = 4'd3,
    ADD     = 4'd4,
    WR_A    = 4'd5,
    WR_B    = 4'd6,
    DONE    = 4'd7,
    HOST_RD = 4'd8
  } state_t;

  // Handshake: an input sample transfers on a rising clk_i edge where in_valid_i and
  // in_ready_o are both high; in_ready_o depends only on state, never on in_valid_i.

  state_t        state;
  logic [AW-1:0] k;
  logic [BW-1:0] b;
  logic [SW-1:0] s;
  logic [CW-1:0] lat;

  logic [AW-1:0] b_ext, hmask, lo, addr_a, addr_b;
  logic [TW-1:0] tw;
  logic          k_last, b_last, s_last, aborting;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Butterfly b at stage s pairs a = (b>>s)*2h + (b mod h) with a+h, h = 2^s.
  always_comb begin
    b_ext  = {1'b0, b};
    hmask  = (AW'(1) << s) - AW'(1);
    lo     = b_ext & hmask;
    addr_a = ((b_ext >> s) << (s + SW'(1))) | lo;
    addr_b = addr_a | (AW'(1) << s);
    tw     = TW'(lo << (SW'(L - 1) - s));
  end

  assign k_last     = (k == AW'(N_POINTS - 1));
  assign b_last     = (b == BW'(N_POINTS / 2 - 1));
  assign s_last     = (s == SW'(L - 1));
  assign aborting   = abort_i && (state != IDLE) && (state != HOST_RD);
  assign in_ready_o = (state == LOAD);
  assign state_o    = state;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      k           <= '0;
      b           <= '0;
      s           <= '0;
      lat         <= '0;
      wr_mem_o    <= 1'b0;
      wr_addr_o   <= '0;
      rd_mem_o    <= 1'b0;
      rd_addr_a_o <= '0;
      rd_addr_b_o <= '0;
      tw_idx_o    <= '0;
      stage_o     <= '0;
      host_sel_o  <= 1'b0;
      busy_o      <= 1'b0;
      done_o      <= 1'b0;
    end else begin
      wr_mem_o    <= 1'b0;
      rd_mem_o    <= 1'b0;
      done_o      <= 1'b0;
      rd_addr_a_o <= addr_a;
      rd_addr_b_o <= addr_b;
      tw_idx_o    <= tw;
      stage_o     <= s;
      host_sel_o  <= (state == HOST_RD);
      busy_o      <= (state != IDLE) && (state != HOST_RD);

      if (aborting) begin
        state <= IDLE;
        k     <= '0;
        b     <= '0;
        s     <= '0;
        lat   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (read_ram_i) begin
              state <= HOST_RD;
            end else if (start_i) begin
              state <= LOAD;
              k     <= '0;
            end
          end
          LOAD: begin
            if (in_valid_i) begin
              wr_mem_o  <= 1'b1;
              wr_addr_o <= bitrev(k);
              if (k_last) begin
                state <= RD;
                k     <= '0;
                b     <= '0;
                s     <= '0;
                lat   <= '0;
              end else begin
                k <= k + AW'(1);
              end
            end
          end
          RD: begin
            if (lat == '0) rd_mem_o <= 1'b1;
            if (lat == CW'(RD_LAT - 1)) begin
              state <= MUL;
              lat   <= '0;
            end else begin
              lat <= lat + CW'(1);
            end
          end
          MUL: begin
            if (lat == CW'(MUL_LAT - 1)) begin
              state <= ADD;
              lat   <= '0;
            end else begin
              lat <= lat + CW'(1);
            end
          end
          ADD: begin
            if (lat == CW'(ADD_LAT - 1)) begin
              state <= WR_A;
              lat   <= '0;
            end else begin
              lat <= lat + CW'(1);
            end
          end
          WR_A: begin
            wr_mem_o  <= 1'b1;
            wr_addr_o <= addr_a;
            state     <= WR_B;
          end
          WR_B: begin
            wr_mem_o  <= 1'b1;
            wr_addr_o <= addr_b;
            if (!b_last) begin
              b     <= b + BW'(1);
              state <= RD;
            end else if (!s_last) begin
              b     <= '0;
              s     <= s + SW'(1);
              state <= RD;
            end else begin
              b     <= '0;
              s     <= '0;
              state <= DONE;
            end
          end
          DONE: begin
            done_o <= 1'b1;
            state  <= IDLE;
          end
          HOST_RD: begin
            if (!read_ram_i) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// Directed bench for fft_seq_ctrl: default instance checked against a write/read scoreboard,
// plus a 64-point RD_LAT=3 instance for timing and asynchronous reset.
module tb_fft_seq_ctrl;
  localparam int N   = 16;
  localparam int L   = 4;
  localparam int AW  = 4;
  localparam int SW  = 3;
  localparam int TW  = 3;
  localparam int GAW = 6;
  localparam int GSW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort_s, read_ram, in_valid;
  logic in_ready, wr_mem, rd_mem, host_sel, busy, done;
  logic [AW-1:0] wr_addr, rd_addr_a, rd_addr_b;
  logic [TW-1:0] tw_idx;
  logic [SW-1:0] stage;
  logic [3:0]    state;

  logic g_rst, g_start, g_abort, g_read_ram, g_in_valid;
  logic g_in_ready, g_wr_mem, g_rd_mem, g_host_sel, g_busy, g_done;
  logic [GAW-1:0] g_wr_addr, g_rd_addr_a, g_rd_addr_b;
  logic [GAW-2:0] g_tw_idx;
  logic [GSW-1:0] g_stage;
  logic [3:0]     g_state;

  fft_seq_ctrl dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .abort_i(abort_s), .read_ram_i(read_ram),
    .in_valid_i(in_valid), .in_ready_o(in_ready), .wr_mem_o(wr_mem), .wr_addr_o(wr_addr),
    .rd_mem_o(rd_mem), .rd_addr_a_o(rd_addr_a), .rd_addr_b_o(rd_addr_b), .tw_idx_o(tw_idx),
    .stage_o(stage), .host_sel_o(host_sel), .busy_o(busy), .done_o(done), .state_o(state)
  );

  fft_seq_ctrl #(.N_POINTS(64), .RD_LAT(3), .MUL_LAT(1), .ADD_LAT(1)) dut_big (
    .clk_i(clk), .rst_i(g_rst), .start_i(g_start), .abort_i(g_abort), .read_ram_i(g_read_ram),
    .in_valid_i(g_in_valid), .in_ready_o(g_in_ready), .wr_mem_o(g_wr_mem), .wr_addr_o(g_wr_addr),
    .rd_mem_o(g_rd_mem), .rd_addr_a_o(g_rd_addr_a), .rd_addr_b_o(g_rd_addr_b), .tw_idx_o(g_tw_idx),
    .stage_o(g_stage), .host_sel_o(g_host_sel), .busy_o(g_busy), .done_o(g_done), .state_o(g_state)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_cnt = 0, rd_cnt = 0, done_cnt = 0, rd_base = 0;
  bit spot_en = 1'b0;
  logic [AW-1:0]        exp_wr_q[$];
  logic [2*AW+TW-1:0]   exp_rd_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int model_bitrev(input int v);
    int r = 0;
    for (int i = 0; i < L; i++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic push_load();
    for (int i = 0; i < N; i++) exp_wr_q.push_back(AW'(model_bitrev(i)));
  endtask

  task automatic push_bf(input int s, input int b, input bit with_wr);
    int h, a, bb, t;
    h  = 1 << s;
    a  = (b / h) * 2 * h + (b % h);
    bb = a + h;
    t  = (b % h) * (N / (2 * h));
    exp_rd_q.push_back({AW'(a), AW'(bb), TW'(t)});
    if (with_wr) begin
      exp_wr_q.push_back(AW'(a));
      exp_wr_q.push_back(AW'(bb));
    end
  endtask

  // Scoreboard side: every strobe from the default instance must match the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (wr_mem) begin
        wr_cnt++;
        if (exp_wr_q.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else check("wr_addr", 32'(wr_addr), 32'(exp_wr_q.pop_front()));
      end
      if (rd_mem) begin
        if (spot_en && (rd_cnt - rd_base) == 21) begin
          check("s2b5_a", 32'(rd_addr_a), 32'd9);
          check("s2b5_b", 32'(rd_addr_b), 32'd13);
          check("s2b5_tw", 32'(tw_idx), 32'd2);
        end
        if (spot_en && (rd_cnt - rd_base) == 31) begin
          check("s3b7_a", 32'(rd_addr_a), 32'd7);
          check("s3b7_b", 32'(rd_addr_b), 32'd15);
          check("s3b7_tw", 32'(tw_idx), 32'd7);
        end
        rd_cnt++;
        if (exp_rd_q.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_ops", 32'({rd_addr_a, rd_addr_b, tw_idx}), 32'(exp_rd_q.pop_front()));
      end
      if (done) done_cnt++;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, wr0, d0;
    rst = 1'b1; start = 1'b0; abort_s = 1'b0; read_ram = 1'b0; in_valid = 1'b0;
    g_rst = 1'b1; g_start = 1'b0; g_abort = 1'b0; g_read_ram = 1'b0; g_in_valid = 1'b0;
    repeat (3) step();

    check("rst_state", 32'(state), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_wr_mem", 32'(wr_mem), 32'd0);
    check("rst_rd_mem", 32'(rd_mem), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_host_sel", 32'(host_sel), 32'd0);
    check("rst_stage", 32'(stage), 32'd0);
    rst = 1'b0; g_rst = 1'b0;
    step();

    // Host read has priority over start.
    read_ram = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    check("host_enter", 32'(state), 32'd8);
    step();
    check("host_sel", 32'(host_sel), 32'd1);
    check("host_busy", 32'(busy), 32'd0);
    read_ram = 1'b0;
    step();
    check("host_exit", 32'(state), 32'd0);
    step();
    check("host_sel_drop", 32'(host_sel), 32'd0);

    // Full default-parameter run.
    push_load();
    for (int s = 0; s < L; s++)
      for (int b = 0; b < N / 2; b++) push_bf(s, b, 1'b1);
    wr0 = wr_cnt; rd_base = rd_cnt; d0 = done_cnt; spot_en = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    check("load_state", 32'(state), 32'd1);
    check("load_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    check("rd_entry", 32'(state), 32'd2);
    t0 = cyc;
    for (int i = 0; i < 400 && state != 4'd7; i++) step();
    check("done_state", 32'(state), 32'd7);
    check("compute_cycles", 32'(cyc - t0), 32'd192);
    step();
    check("done_pulse", 32'(done), 32'd1);
    check("idle_after_done", 32'(state), 32'd0);
    step();
    check("done_low", 32'(done), 32'd0);
    spot_en = 1'b0;
    check("done_count", 32'(done_cnt - d0), 32'd1);
    check("rd_pulses", 32'(rd_cnt - rd_base), 32'd32);
    check("wr_pulses", 32'(wr_cnt - wr0), 32'd80);
    check("wr_q_empty", 32'(exp_wr_q.size()), 32'd0);
    check("rd_q_empty", 32'(exp_rd_q.size()), 32'd0);

    // Abort during MUL of stage 1.
    d0 = done_cnt;
    push_load();
    for (int b = 0; b < N / 2; b++) push_bf(0, b, 1'b1);
    push_bf(1, 0, 1'b0);
    start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < N; i++) begin
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    for (int i = 0; i < 200 && !(state == 4'd3 && stage == 3'd1); i++) step();
    check("mul_s1", 32'(state), 32'd3);
    abort_s = 1'b1;
    step();
    abort_s = 1'b0;
    check("abort_idle", 32'(state), 32'd0);
    repeat (10) step();
    check("abort_no_done", 32'(done_cnt - d0), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_wr_q", 32'(exp_wr_q.size()), 32'd0);
    check("abort_rd_q", 32'(exp_rd_q.size()), 32'd0);

    // Restart begins the load sequence at address 0; abort again on the first RD cycle.
    push_load();
    start = 1'b1;
    step();
    start = 1'b0;
    in_valid = 1'b1;
    step();
    check("restart_wr_mem", 32'(wr_mem), 32'd1);
    check("restart_wr_addr", 32'(wr_addr), 32'd0);
    for (int i = 1; i < N; i++) step();
    in_valid = 1'b0;
    check("restart_rd", 32'(state), 32'd2);
    abort_s = 1'b1;
    step();
    abort_s = 1'b0;
    repeat (8) step();
    check("restart_abort_idle", 32'(state), 32'd0);
    check("restart_wr_q", 32'(exp_wr_q.size()), 32'd0);

    // 64-point instance with RD_LAT=3.
    g_start = 1'b1;
    step();
    g_start = 1'b0;
    for (int i = 0; i < 64; i++) begin
      g_in_valid = 1'b1;
      step();
    end
    g_in_valid = 1'b0;
    check("big_rd_entry", 32'(g_state), 32'd2);
    t0 = cyc;
    for (int i = 0; i < 2000 && g_state != 4'd7; i++) step();
    check("big_done_state", 32'(g_state), 32'd7);
    check("big_cycles", 32'(cyc - t0), 32'd1344);
    step();
    check("big_done_pulse", 32'(g_done), 32'd1);

    // Asynchronous reset in the middle of LOAD.
    g_start = 1'b1;
    step();
    g_start = 1'b0;
    g_in_valid = 1'b1;
    repeat (10) step();
    check("big_load_wr", 32'(g_wr_mem), 32'd1);
    g_rst = 1'b1;
    #1;
    check("arst_state", 32'(g_state), 32'd0);
    check("arst_ready", 32'(g_in_ready), 32'd0);
    check("arst_wr_mem", 32'(g_wr_mem), 32'd0);
    check("arst_wr_addr", 32'(g_wr_addr), 32'd0);
    check("arst_busy", 32'(g_busy), 32'd0);
    step();
    g_rst = 1'b0;
    repeat (3) step();
    check("arst_stay_idle", 32'(g_state), 32'd0);
    check("arst_no_wr", 32'(g_wr_mem), 32'd0);
    g_in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
